// File: rtl/coffee_vend_ctrl.sv
// Coffee vending controller: price check, dispense with timeout, change payout, counter clear.
// Optional macro CANCEL_REFUND_EN enables refunding the whole credit on cancel in IDLE.
module coffee_vend_ctrl #(
    parameter int N       = 8,
    parameter int P0      = 3,
    parameter int P1      = 5,
    parameter int P2      = 7,
    parameter int P3      = 10,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] credit,
    input  logic         sel_valid,
    input  logic [1:0]   sel,
    input  logic         cancel,
    input  logic         disp_done,
    input  logic         change_ack,
    output logic         disp_start,
    output logic [1:0]   disp_prod,
    output logic         cnt_clr,
    output logic         insufficient,
    output logic [N-1:0] change,
    output logic         change_valid,
    output logic         busy,
    output logic         fault
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DISPENSE,
        PAYOUT,
        CLEAR,
        FAULT
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   snap, snap_nxt;
    logic [N-1:0]   change_nxt;
    logic [N-1:0]   price;
    logic [1:0]     prod_nxt;
    logic [CW-1:0]  wait_cnt, wait_nxt;
    logic           start_nxt;
    logic           insuf_nxt;
    logic           cancel_go;

`ifdef CANCEL_REFUND_EN
    assign cancel_go = cancel && (credit != '0);
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_go     = 1'b0;
`endif

    always_comb begin
        price = N'(P0);
        case (disp_prod)
            2'd1:    price = N'(P1);
            2'd2:    price = N'(P2);
            2'd3:    price = N'(P3);
            default: price = N'(P0);
        endcase
    end

    always_comb begin
        state_nxt  = state;
        snap_nxt   = snap;
        change_nxt = change;
        prod_nxt   = disp_prod;
        wait_nxt   = wait_cnt;
        start_nxt  = 1'b0;
        insuf_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // A refund cancel beats a simultaneous selection
                if (cancel_go) begin
                    snap_nxt   = credit;
                    change_nxt = credit;
                    state_nxt  = PAYOUT;
                end else if (sel_valid) begin
                    prod_nxt  = sel;
                    snap_nxt  = credit;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (snap >= price) begin
                    start_nxt = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = DISPENSE;
                end else begin
                    insuf_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DISPENSE: begin
                if (disp_done) begin
                    change_nxt = snap - price;
                    state_nxt  = PAYOUT;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt = FAULT;
                end else begin
                    wait_nxt = wait_cnt + CW'(1);
                end
            end
            PAYOUT: begin
                if (change == '0 || change_ack) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                change_nxt = '0;
                snap_nxt   = '0;
                state_nxt  = IDLE;
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            snap         <= '0;
            change       <= '0;
            disp_prod    <= '0;
            wait_cnt     <= '0;
            disp_start   <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            state        <= state_nxt;
            snap         <= snap_nxt;
            change       <= change_nxt;
            disp_prod    <= prod_nxt;
            wait_cnt     <= wait_nxt;
            disp_start   <= start_nxt;
            insufficient <= insuf_nxt;
        end
    end

    assign change_valid = (state == PAYOUT) && (change != '0);
    assign cnt_clr      = (state == CLEAR);
    assign busy         = (state != IDLE);
    assign fault        = (state == FAULT);

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Scoreboard bench for coffee_vend_ctrl: expected output events are queued by
// the stimulus and matched (kind, value, cycle) by an independent monitor.
module tb_coffee_vend_ctrl;

    localparam int N = 8;

    localparam int EV_START  = 1;
    localparam int EV_INSUF  = 2;
    localparam int EV_CHANGE = 3;
    localparam int EV_CLR    = 4;
    localparam int EV_FAULT  = 5;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] credit;
    logic         sel_valid;
    logic [1:0]   sel;
    logic         cancel;
    logic         disp_done;
    logic         change_ack;
    logic         disp_start;
    logic [1:0]   disp_prod;
    logic         cnt_clr;
    logic         insufficient;
    logic [N-1:0] change;
    logic         change_valid;
    logic         busy;
    logic         fault;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic prev_cv = 1'b0;
    logic prev_fault = 1'b0;

    coffee_vend_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .credit      (credit),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .disp_done   (disp_done),
        .change_ack  (change_ack),
        .disp_start  (disp_start),
        .disp_prod   (disp_prod),
        .cnt_clr     (cnt_clr),
        .insufficient(insufficient),
        .change      (change),
        .change_valid(change_valid),
        .busy        (busy),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input int val, input int c);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, required none",
                     kind, val, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (disp_start)                observe(EV_START, int'(disp_prod));
        if (insufficient)              observe(EV_INSUF, 0);
        if (change_valid && !prev_cv)  observe(EV_CHANGE, int'(change));
        if (cnt_clr)                   observe(EV_CLR, 0);
        if (fault && !prev_fault)      observe(EV_FAULT, 0);
        prev_cv    = change_valid;
        prev_fault = fault;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_disp_start"}, int'(disp_start), 0);
        chk({tag, "_disp_prod"}, int'(disp_prod), 0);
        chk({tag, "_cnt_clr"}, int'(cnt_clr), 0);
        chk({tag, "_insufficient"}, int'(insufficient), 0);
        chk({tag, "_change"}, int'(change), 0);
        chk({tag, "_change_valid"}, int'(change_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_fault"}, int'(fault), 0);
    endtask

    task automatic pulse_sel(input int cr, input int s, input bit cn, output int c);
        credit    = N'(cr);
        sel       = 2'(s);
        cancel    = cn;
        sel_valid = 1'b1;
        c         = cyc;
        tick(1);
        sel_valid = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic pulse_done(output int d);
        disp_done = 1'b1;
        d         = cyc;
        tick(1);
        disp_done = 1'b0;
    endtask

    task automatic pulse_ack(output int a);
        change_ack = 1'b1;
        a          = cyc;
        tick(1);
        change_ack = 1'b0;
    endtask

    initial begin
        int c, d, a;
        rst        = 1'b1;
        credit     = '0;
        sel_valid  = 1'b0;
        sel        = '0;
        cancel     = 1'b0;
        disp_done  = 1'b0;
        change_ack = 1'b0;
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        disp_done  = 1'b1;
        change_ack = 1'b1;
        tick(2);
        disp_done  = 1'b0;
        change_ack = 1'b0;
        chk("idle_ignore_busy", int'(busy), 0);

        // credit 5, product 0: change 2, late credit and stray selection ignored
        push(EV_START, 0, cyc + 2);
        pulse_sel(5, 0, 1'b0, c);
        credit    = 8'd9;
        sel       = 2'd3;
        sel_valid = 1'b1;
        tick(1);
        sel_valid = 1'b0;
        tick(1);
        push(EV_CHANGE, 2, cyc + 1);
        pulse_done(d);
        tick(3);
        chk("change_hold_valid", int'(change_valid), 1);
        chk("change_hold_value", int'(change), 2);
        push(EV_CLR, 0, cyc + 1);
        pulse_ack(a);
        tick(2);
        chk("t1_busy_low", int'(busy), 0);

        // credit 4, product 3: insufficient
        push(EV_INSUF, 0, cyc + 2);
        pulse_sel(4, 3, 1'b0, c);
        tick(3);
        chk("t2_busy_low", int'(busy), 0);

        // credit exactly price: zero change, PAYOUT one cycle
        push(EV_START, 1, cyc + 2);
        pulse_sel(5, 1, 1'b0, c);
        tick(2);
        push(EV_CLR, 0, cyc + 2);
        pulse_done(d);
        tick(3);
        chk("t3_busy_low", int'(busy), 0);

        // credit 20, product 2: change 13, immediate ack
        push(EV_START, 2, cyc + 2);
        pulse_sel(20, 2, 1'b0, c);
        tick(2);
        push(EV_CHANGE, 13, cyc + 1);
        pulse_done(d);
        push(EV_CLR, 0, cyc + 1);
        pulse_ack(a);
        tick(2);
        chk("t4_busy_low", int'(busy), 0);

        // cancel with zero credit: ignored, selection proceeds
        cancel = 1'b1;
        credit = '0;
        tick(2);
        cancel = 1'b0;
        chk("cancel_zero_busy", int'(busy), 0);
        push(EV_INSUF, 0, cyc + 2);
        pulse_sel(0, 0, 1'b1, c);
        tick(3);

        // cancel and selection together, credit 6
`ifdef CANCEL_REFUND_EN
        push(EV_CHANGE, 6, cyc + 1);
        pulse_sel(6, 1, 1'b1, c);
        tick(1);
        push(EV_CLR, 0, cyc + 1);
        pulse_ack(a);
`else
        push(EV_START, 1, cyc + 2);
        pulse_sel(6, 1, 1'b1, c);
        tick(2);
        push(EV_CHANGE, 1, cyc + 1);
        pulse_done(d);
        push(EV_CLR, 0, cyc + 1);
        pulse_ack(a);
`endif
        tick(2);
        chk("t5_busy_low", int'(busy), 0);

        // reset during PAYOUT with change pending
        push(EV_START, 0, cyc + 2);
        pulse_sel(9, 0, 1'b0, c);
        tick(2);
        push(EV_CHANGE, 6, cyc + 1);
        pulse_done(d);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all_zero("payout_rst");
        tick(1);
        chk("payout_rst_no_clr", int'(cnt_clr), 0);

        // dispenser never completes: fault after 255 cycles in DISPENSE
        push(EV_START, 0, cyc + 2);
        push(EV_FAULT, 0, cyc + 257);
        pulse_sel(5, 0, 1'b0, c);
        tick(250);
        chk("no_fault_early", int'(fault), 0);
        tick(10);
        chk("fault_set", int'(fault), 1);
        sel_valid  = 1'b1;
        disp_done  = 1'b1;
        change_ack = 1'b1;
        tick(3);
        sel_valid  = 1'b0;
        disp_done  = 1'b0;
        change_ack = 1'b0;
        chk("fault_sticky", int'(fault), 1);
        chk("fault_busy", int'(busy), 1);
        chk("fault_no_clr", int'(cnt_clr), 0);
        chk("fault_no_cv", int'(change_valid), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all_zero("fault_rst");

        // recovery after reset
        push(EV_INSUF, 0, cyc + 2);
        pulse_sel(2, 0, 1'b0, c);
        tick(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
